alu_exec: RTL and testbench

Registered execution unit that consumes the 6-bit ALUctrl code produced by the ALU controller and performs the selected operation on two 32-bit operands. Logical, arithmetic, compare, LUI and fixed-amount shift codes complete in one cycle. Code 0x13 (multiply unsigned) runs as a 32-cycle shift-add sequence that writes the hi/lo register pair read by MFHI/MFLO. The block sits in the execute stage, between the ALU controller and the register-file writeback, and stalls the datapath through `busy`.

---
 rtl/alu_exec_pkg.sv | 39 +++
 rtl/alu_defs.sv | 26 ++
 rtl/alu_exec_mul_seq.sv | 56 +++++
 rtl/alu_exec.sv | 135 +++++++++++++
 tb/tb_alu_exec.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: types and constants shared by the execute unit.
// Contents: default operand width, FSM state type, typed copies of the
// ALUctrl codes, and a helper that recognises the multi-cycle opcode.
package alu_exec_pkg;
`ifndef ALU_DEFS_VH
`include "alu_defs.sv"
`endif

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam logic [5:0] OP_AND   = `ALU_AND;
  localparam logic [5:0] OP_OR    = `ALU_OR;
  localparam logic [5:0] OP_ADD   = `ALU_ADD;
  localparam logic [5:0] OP_ADDU  = `ALU_ADDU;
  localparam logic [5:0] OP_XOR   = `ALU_XOR;
  localparam logic [5:0] OP_SUB   = `ALU_SUB;
  localparam logic [5:0] OP_SLT   = `ALU_SLT;
  localparam logic [5:0] OP_SLTU  = `ALU_SLTU;
  localparam logic [5:0] OP_LUI   = `ALU_LUI;
  localparam logic [5:0] OP_SLL1  = `ALU_SLL1;
  localparam logic [5:0] OP_SLL2  = `ALU_SLL2;
  localparam logic [5:0] OP_SLL8  = `ALU_SLL8;
  localparam logic [5:0] OP_SRL1  = `ALU_SRL1;
  localparam logic [5:0] OP_SRL2  = `ALU_SRL2;
  localparam logic [5:0] OP_SRL8  = `ALU_SRL8;
  localparam logic [5:0] OP_SRA1  = `ALU_SRA1;
  localparam logic [5:0] OP_SRA2  = `ALU_SRA2;
  localparam logic [5:0] OP_SRA8  = `ALU_SRA8;
  localparam logic [5:0] OP_MULTU = `ALU_MULTU;

  function automatic logic is_mul(input logic [5:0] code);
    return code == OP_MULTU;
  endfunction
endpackage

// File: rtl/alu_defs.sv
// alu_defs: shared ALUctrl operation codes.
// Both the ALU controller and the execute unit pull these in, so the two
// sides always agree on the encoding. The guard keeps repeated inclusion
// (or compiling this file on its own) harmless.
`ifndef ALU_DEFS_VH
`define ALU_DEFS_VH
`define ALU_AND    6'h00
`define ALU_OR     6'h01
`define ALU_ADD    6'h02
`define ALU_ADDU   6'h03
`define ALU_XOR    6'h04
`define ALU_SUB    6'h06
`define ALU_SLT    6'h07
`define ALU_SLTU   6'h08
`define ALU_LUI    6'h09
`define ALU_SLL1   6'h0A
`define ALU_SLL2   6'h0B
`define ALU_SLL8   6'h0C
`define ALU_SRL1   6'h0D
`define ALU_SRL2   6'h0E
`define ALU_SRL8   6'h0F
`define ALU_SRA1   6'h10
`define ALU_SRA2   6'h11
`define ALU_SRA8   6'h12
`define ALU_MULTU  6'h13
`endif

// File: rtl/alu_exec_mul_seq.sv
// mul_seq: unsigned shift-add multiplier, one multiplier bit per step.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   load          - capture a (multiplicand) and b (multiplier), clear state
//   step          - consume one multiplier bit
//   a, b          - operands, sampled only on load
//   product_next  - accumulator value after the current step
//   last          - current step is the final (WIDTH-th) one
module mul_seq
  #(parameter int WIDTH = 32)
  (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product_next,
    output logic               last
  );

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  // Exposing the post-step sum lets the parent latch the finished product
  // on the same edge as the final step instead of one cycle later.
  always_comb begin
    product_next = acc + (mplier[0] ? mcand : '0);
    last         = (count == CW'(WIDTH - 1));
  end

  // The multiplicand walks left while the multiplier walks right, so the
  // low multiplier bit always selects the correctly weighted addend.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      count  <= '0;
    end else if (step) begin
      acc    <= product_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
    end
  end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: registered execute-stage ALU with a sequential unsigned multiply.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   start        - operation request, honoured only while busy is low
//   ALUctrl      - 6-bit operation code from the ALU controller
//   a, b         - operands
//   result/zero/overflow - registered outcome of the last single-cycle op
//   hi, lo       - product words written by MULTU
//   busy         - multiply in flight; start requests are dropped
//   done         - one-cycle completion pulse per accepted request
module alu_exec
  import alu_exec_pkg::*;
  #(parameter int WIDTH = WIDTH_DEFAULT)
  (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       ALUctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
  );

  state_t             state;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic               mul_load;
  logic               mul_step;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_next;

  // Single-cycle operation mux; unknown codes fall through to zero.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    sum     = a + b;
    diff    = a - b;
    case (ALUctrl)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADDU: alu_res = sum;
      OP_XOR:  alu_res = a ^ b;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_LUI:  alu_res = b << 16;
      OP_SLL1: alu_res = b << 1;
      OP_SLL2: alu_res = b << 2;
      OP_SLL8: alu_res = b << 8;
      OP_SRL1: alu_res = b >> 1;
      OP_SRL2: alu_res = b >> 2;
      OP_SRL8: alu_res = b >> 8;
      OP_SRA1: alu_res = $signed(b) >>> 1;
      OP_SRA2: alu_res = $signed(b) >>> 2;
      OP_SRA8: alu_res = $signed(b) >>> 8;
      default: alu_res = '0;
    endcase
  end

  // The multiplier captures its own operand copies on load, so later
  // changes to a/b cannot disturb a multiply in flight.
  assign mul_load = (state == ST_IDLE) && start && is_mul(ALUctrl);
  assign mul_step = (state == ST_MUL);

  mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .reset        (reset),
    .load         (mul_load),
    .step         (mul_step),
    .a            (a),
    .b            (b),
    .product_next (mul_next),
    .last         (mul_last)
  );

  // Control FSM plus output registers; done defaults low so it can only
  // ever be a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_mul(ALUctrl)) begin
              state <= ST_MUL;
              busy  <= 1'b1;
            end else begin
              result   <= alu_res;
              zero     <= (alu_res == '0);
              overflow <= alu_ovf;
              done     <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_last) begin
            hi    <= mul_next[2*WIDTH-1:WIDTH];
            lo    <= mul_next[WIDTH-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed self-checking bench for alu_exec.
// Drives requests on the falling edge and samples 1 time unit after the
// rising edge; every expected value below is worked out by hand.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  ALUctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  alu_exec #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ALUctrl  (ALUctrl),
    .a        (a),
    .b        (b),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // One-cycle start pulse; returns just after the edge that sampled it.
  task automatic applyStimulus(input logic [5:0] code, input logic [31:0] op_a,
                               input logic [31:0] op_b);
    @(negedge clk);
    ALUctrl = code;
    a       = op_a;
    b       = op_b;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Bounded wait for done; the edge count lets callers check latency.
  task automatic waitDone(input int limit, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  // Global guard so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single-cycle vectors: code, a, b, expected result, zero, overflow.
  typedef struct {
    logic [5:0]  code;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] res;
    logic        z;
    logic        ov;
  } vec_t;

  vec_t singles[12];
  vec_t chain[4];

  initial begin
    int n;
    int seen;

    singles[0]  = '{6'h02, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    singles[1]  = '{6'h06, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    singles[2]  = '{6'h06, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    singles[3]  = '{6'h03, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
    singles[4]  = '{6'h07, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    singles[5]  = '{6'h08, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    singles[6]  = '{6'h0A, 32'h00000000, 32'h80000001, 32'h00000002, 1'b0, 1'b0};
    singles[7]  = '{6'h0C, 32'h00000000, 32'h80000001, 32'h00000100, 1'b0, 1'b0};
    singles[8]  = '{6'h0F, 32'h00000000, 32'h80000001, 32'h00800000, 1'b0, 1'b0};
    singles[9]  = '{6'h10, 32'h00000000, 32'h80000001, 32'hC0000000, 1'b0, 1'b0};
    singles[10] = '{6'h12, 32'h00000000, 32'h80000001, 32'hFF800000, 1'b0, 1'b0};
    singles[11] = '{6'h09, 32'h00000000, 32'h00001234, 32'h12340000, 1'b0, 1'b0};

    chain[0] = '{6'h02, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    chain[1] = '{6'h3F, 32'h00001234, 32'h00005678, 32'h00000000, 1'b1, 1'b0};
    chain[2] = '{6'h00, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0};
    chain[3] = '{6'h01, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1'b0};

    reset   = 1'b1;
    start   = 1'b0;
    ALUctrl = 6'h00;
    a       = '0;
    b       = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_result",   result,   0);
    checkOutput("rst_zero",     zero,     1);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_hi",       hi,       0);
    checkOutput("rst_lo",       lo,       0);
    checkOutput("rst_busy",     busy,     0);
    checkOutput("rst_done",     done,     0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(singles[i].code, singles[i].va, singles[i].vb);
      checkOutput($sformatf("op%0h_result", singles[i].code), result, singles[i].res);
      checkOutput($sformatf("op%0h_zero", singles[i].code), zero, singles[i].z);
      checkOutput($sformatf("op%0h_ovf", singles[i].code), overflow, singles[i].ov);
      checkOutput($sformatf("op%0h_done", singles[i].code), done, 1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("op%0h_done_drop", singles[i].code), done, 0);
    end

    // MULTU with operands changed and a second start issued mid-flight.
    applyStimulus(6'h13, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checkOutput("mul_busy_start", busy, 1);
    checkOutput("mul_no_done", done, 0);
    a = 32'h00000002;
    b = 32'h00000003;
    repeat (4) @(posedge clk);
    @(negedge clk);
    ALUctrl = 6'h02;
    a       = 32'h00000001;
    b       = 32'h00000001;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("mul_busy_mid", busy, 1);
    checkOutput("mul_drop_done", done, 0);
    waitDone(40, n);
    checkOutput("mul_latency", 64'(n + 5), 32);
    checkOutput("mul_hi", hi, 32'hFFFFFFFE);
    checkOutput("mul_lo", lo, 32'h00000001);
    checkOutput("mul_busy_end", busy, 0);
    checkOutput("mul_result_kept", result, 32'h12340000);
    @(posedge clk);
    #1;
    checkOutput("mul_done_drop", done, 0);
    checkOutput("mul_result_after", result, 32'h12340000);

    // Reset ten cycles into a multiply aborts it with no done pulse.
    applyStimulus(6'h13, 32'h00000003, 32'h00000004);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_busy",   busy,   0);
    checkOutput("abort_hi",     hi,     0);
    checkOutput("abort_lo",     lo,     0);
    checkOutput("abort_done",   done,   0);
    checkOutput("abort_result", result, 0);
    checkOutput("abort_zero",   zero,   1);
    @(negedge clk);
    reset = 1'b0;
    seen  = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    checkOutput("abort_no_done", 64'(seen), 0);

    applyStimulus(6'h13, 32'h00000003, 32'h00000004);
    waitDone(40, n);
    checkOutput("mul2_latency", 64'(n), 32);
    checkOutput("mul2_lo", lo, 12);
    checkOutput("mul2_hi", hi, 0);

    // Start on the very next edge after the multiply done is accepted.
    applyStimulus(6'h04, 32'h0000F0F0, 32'h0000FF00);
    checkOutput("xor_after_mul_done", done, 1);
    checkOutput("xor_after_mul_result", result, 32'h00000FF0);
    checkOutput("xor_after_mul_lo", lo, 12);

    // Back-to-back requests with start held high every cycle.
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ALUctrl = chain[i].code;
      a       = chain[i].va;
      b       = chain[i].vb;
      @(posedge clk);
      #1;
      checkOutput($sformatf("b2b%0d_result", i), result, chain[i].res);
      checkOutput($sformatf("b2b%0d_zero", i), zero, chain[i].z);
      checkOutput($sformatf("b2b%0d_ovf", i), overflow, chain[i].ov);
      checkOutput($sformatf("b2b%0d_done", i), done, 1);
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("b2b_done_drop", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
